// File: rtl/regfile_read_port_pkg.sv
// regfile_read_port_pkg: shared widths and count-state encodings for the register-file read port.
package regfile_read_port_pkg;
    localparam int DATA_W = 21;
    localparam int ADDR_W = 3;
    localparam int NREGS  = 8;
    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;
endpackage

// File: rtl/regfile_read_port_operand_sel.sv
// rf_operand_sel: NREGS:1 operand select; REGFILE_RD_BYPASS_EN adds write-to-read bypass.
module rf_operand_sel
    import regfile_read_port_pkg::*;
(
    input  logic [NREGS*DATA_W-1:0] reg_bus_i,
    input  logic [ADDR_W-1:0]       addr_i,
    input  logic                    wr_en_i,
    input  logic [ADDR_W-1:0]       wr_addr_i,
    input  logic [DATA_W-1:0]       wr_data_i,
    output logic [DATA_W-1:0]       data_o
);
    logic [DATA_W-1:0] reg_val;
    always_comb begin
        reg_val = '0;
        for (int k = 0; k < NREGS; k++)
            if (addr_i == k[ADDR_W-1:0]) reg_val = reg_bus_i[k*DATA_W +: DATA_W];
    end
`ifdef REGFILE_RD_BYPASS_EN
    assign data_o = (wr_en_i && wr_addr_i == addr_i) ? wr_data_i : reg_val;
`else
    // Write port is intentionally ignored: same-cycle reads see the old value.
    logic unused_wr;
    assign unused_wr = ^{wr_en_i, wr_addr_i, wr_data_i};
    assign data_o = reg_val;
`endif
endmodule

// File: rtl/regfile_read_port.sv
// regfile_read_port: two-operand read port with a 2-entry response skid FIFO.
// Optional same-cycle write bypass under REGFILE_RD_BYPASS_EN.
module regfile_read_port
    import regfile_read_port_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREGS*DATA_W-1:0] reg_bus_i,
    input  logic                    wr_en_i,
    input  logic [ADDR_W-1:0]       wr_addr_i,
    input  logic [DATA_W-1:0]       wr_data_i,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [ADDR_W-1:0]       req_addr_a_i,
    input  logic [ADDR_W-1:0]       req_addr_b_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [DATA_W-1:0]       rsp_data_a_o,
    output logic [DATA_W-1:0]       rsp_data_b_o
);
    logic [1:0]          count_q, count_d;
    logic                head_q, head_d, tail_q, tail_d;
    logic [2*DATA_W-1:0] mem_q [2];
    logic [2*DATA_W-1:0] mem_d [2];
    logic [DATA_W-1:0]   sel_a, sel_b;
    logic                acc, pop;

    rf_operand_sel u_sel_a (
        .reg_bus_i(reg_bus_i), .addr_i(req_addr_a_i), .wr_en_i(wr_en_i),
        .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i), .data_o(sel_a)
    );
    rf_operand_sel u_sel_b (
        .reg_bus_i(reg_bus_i), .addr_i(req_addr_b_i), .wr_en_i(wr_en_i),
        .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i), .data_o(sel_b)
    );

    // Handshakes are masked during reset so nothing is accepted or popped.
    assign req_ready_o = !rst && count_q != FULL;
    assign rsp_valid_o = !rst && count_q != EMPTY;
    assign acc = req_valid_i && req_ready_o;
    assign pop = rsp_valid_o && rsp_ready_i;
    assign {rsp_data_a_o, rsp_data_b_o} = mem_q[head_q];

    always_comb begin
        mem_d = mem_q;
        mem_d[tail_q] = acc ? {sel_a, sel_b} : mem_q[tail_q];
        count_d = count_q + {1'b0, acc} - {1'b0, pop};
        head_d = head_q ^ pop;
        tail_d = tail_q ^ acc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= EMPTY;
            head_q  <= 1'b0;
            tail_q  <= 1'b0;
            mem_q   <= '{default: '0};
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            mem_q   <= mem_d;
        end
    end
endmodule

// File: tb/tb_regfile_read_port.sv
// tb_regfile_read_port: directed stimulus with a queue scoreboard and a decoupled response monitor.
module tb_regfile_read_port;
    logic        clk = 0;
    logic        rst;
    logic [167:0] reg_bus;
    logic        wr_en_i;
    logic [2:0]  wr_addr_i;
    logic [20:0] wr_data_i;
    logic        req_valid_i, req_ready_o;
    logic [2:0]  req_addr_a_i, req_addr_b_i;
    logic        rsp_valid_o, rsp_ready_i;
    logic [20:0] rsp_data_a_o, rsp_data_b_o;
    logic [20:0] regs [8];
    logic [41:0] exp_q [$];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    always_comb begin
        reg_bus = '0;
        for (int k = 0; k < 8; k++) reg_bus[k*21 +: 21] = regs[k];
    end

    regfile_read_port dut (
        .clk(clk), .rst(rst), .reg_bus_i(reg_bus),
        .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_addr_a_i(req_addr_a_i), .req_addr_b_i(req_addr_b_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_data_a_o(rsp_data_a_o), .rsp_data_b_o(rsp_data_b_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Monitor: every presented response must match the scoreboard head; pop on transfer.
    always @(negedge clk) begin
        if (!rst && rsp_valid_o) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp at %0t: got a=0x%0h b=0x%0h, expected none", $time, rsp_data_a_o, rsp_data_b_o);
            end else begin
                chk("rsp_a", 32'(rsp_data_a_o), 32'(exp_q[0][41:21]));
                chk("rsp_b", 32'(rsp_data_b_o), 32'(exp_q[0][20:0]));
                if (rsp_ready_i) void'(exp_q.pop_front());
            end
        end
    end

    task automatic issue(input logic [2:0] a, input logic [2:0] b, input logic [20:0] ea, input logic [20:0] eb);
        bit done = 0;
        req_valid_i = 1; req_addr_a_i = a; req_addr_b_i = b;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (req_ready_o) begin
                @(posedge clk);
                exp_q.push_back({ea, eb});
                done = 1;
            end else @(posedge clk);
        end
        #1 req_valid_i = 0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout at %0t: got no accept, expected accept within 20 cycles", $time);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        #1 chk("drain_left", 32'(exp_q.size()), 0);
    endtask

    initial begin
        rst = 1; wr_en_i = 0; wr_addr_i = 0; wr_data_i = 0;
        req_valid_i = 0; req_addr_a_i = 0; req_addr_b_i = 0; rsp_ready_i = 0;
        for (int k = 0; k < 8; k++) regs[k] = 21'(k * 'h1111);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(req_ready_o), 0);
        chk("rst_valid", 32'(rsp_valid_o), 0);
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        chk("post_rst_ready", 32'(req_ready_o), 1);
        chk("post_rst_valid", 32'(rsp_valid_o), 0);
        chk("post_rst_a", 32'(rsp_data_a_o), 0);
        chk("post_rst_b", 32'(rsp_data_b_o), 0);
        @(posedge clk); #1;

        rsp_ready_i = 1;
        issue(3, 5, 21'h03333, 21'h05555);
        @(negedge clk);
        chk("latency_valid", 32'(rsp_valid_o), 1);
        @(negedge clk);
        chk("drop_valid", 32'(rsp_valid_o), 0);
        @(posedge clk); #1;

        rsp_ready_i = 0;
        issue(1, 2, 21'h01111, 21'h02222);
        issue(3, 4, 21'h03333, 21'h04444);
        fork
            issue(5, 6, 21'h05555, 21'h06666);
            begin
                repeat (3) begin
                    @(negedge clk);
                    chk("full_ready", 32'(req_ready_o), 0);
                end
                @(posedge clk); #1 rsp_ready_i = 1;
            end
        join
        drain();

        rsp_ready_i = 0;
        issue(2, 0, 21'h02222, 21'h00000);
        regs[2] = 21'h1ABCD;
        repeat (3) @(posedge clk);
        #1 rsp_ready_i = 1;
        drain();
        regs[2] = 21'h02222;

        wr_en_i = 1; wr_addr_i = 4; wr_data_i = 21'h15A5A;
`ifdef REGFILE_RD_BYPASS_EN
        issue(4, 4, 21'h15A5A, 21'h15A5A);
`else
        issue(4, 4, 21'h04444, 21'h04444);
`endif
        wr_addr_i = 6;
`ifdef REGFILE_RD_BYPASS_EN
        issue(6, 1, 21'h15A5A, 21'h01111);
`else
        issue(6, 1, 21'h06666, 21'h01111);
`endif
        wr_en_i = 0;
        drain();

        for (int i = 0; i < 10; i++) begin
            req_valid_i = 1; req_addr_a_i = i[2:0]; req_addr_b_i = 3'(i + 3);
            @(negedge clk);
            chk("stream_ready", 32'(req_ready_o), 1);
            if (i > 0) chk("stream_valid", 32'(rsp_valid_o), 1);
            @(posedge clk);
            exp_q.push_back({21'((i % 8) * 'h1111), 21'(((i + 3) % 8) * 'h1111)});
            #1;
        end
        req_valid_i = 0;
        drain();

        rsp_ready_i = 0;
        issue(1, 2, 21'h01111, 21'h02222);
        issue(3, 4, 21'h03333, 21'h04444);
        @(negedge clk);
        chk("pre_rst_ready", 32'(req_ready_o), 0);
        @(posedge clk); #1 rst = 1;
        exp_q.delete();
        @(negedge clk);
        chk("mid_rst_valid", 32'(rsp_valid_o), 0);
        chk("mid_rst_ready", 32'(req_ready_o), 0);
        @(posedge clk); #1 rst = 0; rsp_ready_i = 1;
        repeat (3) begin
            @(negedge clk);
            chk("after_rst_ready", 32'(req_ready_o), 1);
            chk("after_rst_valid", 32'(rsp_valid_o), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/regfile_read_port.md
Name: regfile_read_port

Overview:
- Read side of the 21-bit, 8-entry register file; the write side uses the 3x8 enable decoder and the parallel-load registers.
- Accepts two-operand read requests over a valid/ready handshake and returns both 21-bit operands one cycle later.
- Holds up to two responses in a skid buffer, so a consumer stall never drops or corrupts data.
- Optional same-cycle write-to-read bypass, so a read issued alongside a write returns the new value.

Parameters:
- DATA_W, 21, operand width.
- ADDR_W, 3, register address width.
- NREGS, 8, register count; must equal 2**ADDR_W.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- reg_bus_i  in  NREGS*DATA_W  current register outputs, flattened; reg k at [k*DATA_W +: DATA_W]
- wr_en_i  in  1  register-file write strobe (same as decoder enable)
- wr_addr_i  in  ADDR_W  write address
- wr_data_i  in  DATA_W  write data
- req_valid_i  in  1  read request valid
- req_ready_o  out  1  request accepted when valid and ready
- req_addr_a_i  in  ADDR_W  operand A address
- req_addr_b_i  in  ADDR_W  operand B address
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  consumer ready
- rsp_data_a_o  out  DATA_W  operand A
- rsp_data_b_o  out  DATA_W  operand B

Behaviour:
- Reset:
  - count=0 (state EMPTY).
  - rsp_valid_o=0; rsp_data_a_o and rsp_data_b_o read 0.
  - req_ready_o=1 from the first cycle after rst deasserts; req_ready_o=0 while rst is high.
- Storage: 2-entry FIFO of {data_a, data_b}, with a head pointer, a tail pointer and a 2-bit count.
- State = count: EMPTY(0), ONE(1), FULL(2).
- Accept and pop:
  - acc = req_valid_i & req_ready_o.
  - pop = rsp_valid_o & rsp_ready_i.
  - req_ready_o = (count != FULL). It depends on state only, with no combinational path from rsp_ready_i.
- Transitions:
  - EMPTY: acc goes to ONE; otherwise stay.
  - ONE: acc & !pop goes to FULL; !acc & pop goes to EMPTY; acc & pop stays in ONE, and the head advances to the new entry.
  - FULL: pop goes to ONE; acc is impossible.
- Latency: a request accepted at edge N is presented with rsp_valid_o=1 after edge N if the FIFO was empty. Otherwise it is presented in FIFO order.
- Capture: on acc, the entry gets reg_bus_i[addr] for each operand, sampled at that edge (snapshot semantics).
  - Later register writes do not alter a buffered entry.
  - Outputs stay stable while rsp_valid_o & !rsp_ready_i.
- Bypass (macro enabled): if wr_en_i and wr_addr_i equals an operand address in the accept cycle, that operand captures wr_data_i instead of reg_bus_i.
  - A and B bypass independently.
  - The A==B==wr_addr case returns wr_data_i on both.
- Outputs: when count=0, the data outputs are don't-care, but the implementation drives the head entry (which is 0 after reset).
- Reset mid-operation: rst clears count and both pointers in the same edge. Buffered responses are discarded and the handshake inputs are ignored that cycle.
- Addresses are always in range (NREGS = 2**ADDR_W); no out-of-range handling.

Optional Feature:
- REGFILE_RD_BYPASS_EN:
  - Defined: the bypass described above is compiled in.
  - Undefined: wr_en_i, wr_addr_i and wr_data_i are unused. A read in the same cycle as a write to the same address returns the old register value.
  - Ports exist in both builds.

Decomposition:
- Shared package/header holds:
  - DATA_W=21, ADDR_W=3, NREGS=8.
  - Count state encodings: EMPTY=2'd0, ONE=2'd1, FULL=2'd2.
- Sub-module rf_operand_sel: combinational NREGS:1 DATA_W-bit select with the bypass compare.
  - Instantiated once per operand.
  - Contains the `ifdef REGFILE_RD_BYPASS_EN.
- FIFO and control remain in regfile_read_port.

Test Plan:
- Reset, then regs[k]=k*0x1111, request A=3,B=5 with rsp_ready_i=1 -> one cycle later rsp_valid_o=1, A=0x03333, B=0x05555; request then dropped -> rsp_valid_o=0 next cycle.
- rsp_ready_i=0, three back-to-back requests (1,2),(3,4),(5,6) -> first two accepted, req_ready_o=0 while FULL, third held. Raise rsp_ready_i -> responses (0x01111,0x02222),(0x03333,0x04444),(0x05555,0x06666) in order, no loss.
- Buffered response (A=2) stalled, then reg2 written to 0x1ABCD -> stalled output still 0x02222 until popped.
- Macro defined: wr_en_i=1, wr_addr_i=4, wr_data_i=0x15A5A with request A=4,B=4 -> both operands 0x15A5A. Macro undefined, same stimulus -> both operands 0x04444.
- Continuous acc & pop in ONE for 10 cycles with addresses 0..7 cycling -> one response per cycle, count stays 1, data matches regs[addr].
- FULL state, assert rst for one cycle -> rsp_valid_o=0 and req_ready_o=0 during rst. After rst drops, req_ready_o=1 and no stale response appears.
